// File: rtl/downsizing_pkg.sv
// Shared types for the downsizing width converter (2*W-bit in, W-bit out).
package downsizing_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        UPPER = 2'd1,
        LOWER = 2'd2
    } state_e;

endpackage

// File: rtl/downsizing.sv
// AXI-Stream 2*W -> W downsizer: emits the upper half of each word, then the lower half.
// Optional build macro DOWNSIZING_TLAST_EN adds in_tlast/out_tlast (flag rides on the second beat).
module downsizing
    import downsizing_pkg::*;
#(
    parameter int W = 40
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [2*W-1:0]   in_tdata,
    input  logic             in_tvalid,
    output logic             in_tready,
    output logic [W-1:0]     out_tdata,
    output logic             out_tvalid,
    input  logic             out_tready,
`ifdef DOWNSIZING_TLAST_EN
    input  logic             in_tlast,
    output logic             out_tlast,
`endif
    output state_e           dbg_state
);

    // Handshake semantics: a beat transfers on a rising edge where valid & ready are both 1;
    // valid never waits on ready, and in_tready depends only on state and out_tready.

    state_e           state_q, state_d;
    logic [2*W-1:0]   data_q, data_d;
    logic             in_hs;
    logic             out_hs;

    assign in_hs  = in_tvalid & in_tready;
    assign out_hs = out_tvalid & out_tready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // The data register is deliberately not reset; it is only meaningful outside EMPTY.
    always_ff @(posedge aclk) begin
        data_q <= data_d;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (in_hs) begin
            data_d = in_tdata;
        end
        case (state_q)
            EMPTY: begin
                if (in_hs) begin
                    state_d = UPPER;
                end
            end
            UPPER: begin
                if (out_hs) begin
                    state_d = LOWER;
                end
            end
            LOWER: begin
                if (out_hs) begin
                    state_d = in_hs ? UPPER : EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        in_tready  = (state_q == EMPTY) | ((state_q == LOWER) & out_tready);
        out_tvalid = (state_q != EMPTY);
        out_tdata  = (state_q == UPPER) ? data_q[2*W-1:W] : data_q[W-1:0];
        dbg_state  = state_q;
    end

`ifdef DOWNSIZING_TLAST_EN
    logic last_q, last_d;

    always_ff @(posedge aclk) begin
        if (areset) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d    = in_hs ? in_tlast : last_q;
        out_tlast = last_q & (state_q == LOWER);
    end
`endif

endmodule

// File: tb/tb_downsizing.sv
// Self-checking bench for downsizing: directed scenarios plus random backpressure,
// checked against a queue of pending output beats.
module tb_downsizing;
    import downsizing_pkg::*;

    localparam int W = 40;

    logic           aclk = 1'b0;
    logic           areset;
    logic [2*W-1:0] in_tdata;
    logic           in_tvalid;
    logic           in_tready;
    logic [W-1:0]   out_tdata;
    logic           out_tvalid;
    logic           out_tready;
    logic           in_tlast;
    state_e         dbg_state;
`ifdef DOWNSIZING_TLAST_EN
    logic           out_tlast;
`endif

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;

    downsizing #(.W(W)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
`ifdef DOWNSIZING_TLAST_EN
        .in_tlast   (in_tlast),
        .out_tlast  (out_tlast),
`endif
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    // exp_q holds the output beats still owed, in emission order (at most two).
    logic [W-1:0] exp_q[$];
    logic         exp_last_q[$];
    int           vectors     = 0;
    int           miscompares = 0;

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, then advance the model on the rising edge.
    task automatic cycle(output bit in_hs);
        bit     exp_vld, exp_rdy, out_hs;
        state_e exp_state;
        @(negedge aclk);
        exp_vld   = (exp_q.size() != 0);
        exp_rdy   = (exp_q.size() == 0) || (exp_q.size() == 1 && out_tready);
        exp_state = (exp_q.size() == 0) ? EMPTY : (exp_q.size() == 2) ? UPPER : LOWER;
        chk("out_tvalid", 80'(out_tvalid), 80'(exp_vld));
        chk("in_tready", 80'(in_tready), 80'(exp_rdy));
        chk("state", 80'(dbg_state), 80'(exp_state));
        if (exp_vld) begin
            chk("out_tdata", 80'(out_tdata), 80'(exp_q[0]));
`ifdef DOWNSIZING_TLAST_EN
            chk("out_tlast", 80'(out_tlast), 80'(exp_last_q[0]));
`endif
        end
        in_hs  = in_tvalid && exp_rdy && !areset;
        out_hs = exp_vld && out_tready;
        @(posedge aclk);
        if (areset) begin
            exp_q.delete();
            exp_last_q.delete();
        end else begin
            if (out_hs) begin
                void'(exp_q.pop_front());
                void'(exp_last_q.pop_front());
            end
            if (in_hs) begin
                exp_q.push_back(in_tdata[2*W-1:W]);
                exp_q.push_back(in_tdata[W-1:0]);
                exp_last_q.push_back(1'b0);
                exp_last_q.push_back(in_tlast);
            end
        end
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        areset     = 1'b1;
        in_tvalid  = 1'b0;
        in_tdata   = '0;
        in_tlast   = 1'b0;
        out_tready = 1'b0;
        repeat (2) @(posedge aclk);
        exp_q.delete();
        exp_last_q.delete();
        #1;
        areset = 1'b0;
    endtask

    task automatic send_word(input logic [2*W-1:0] d, input logic last);
        bit hs;
        hs        = 1'b0;
        in_tdata  = d;
        in_tlast  = last;
        in_tvalid = 1'b1;
        for (int i = 0; i < 100 && !hs; i++) begin
            cycle(hs);
        end
        if (!hs) chk("send_timeout", 80'(hs), 80'(1));
        in_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit hs;
        for (int i = 0; i < n; i++) begin
            cycle(hs);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [2*W-1:0] w_a, w_k, w_d;
        logic [95:0]    r;
        bit             hs;
        int             budget;

        w_a = "ABCDEFGHIJ";
        w_k = "KLMNOPQRST";
        w_d = "0123456789";

        do_reset();
        idle(1);
        chk("reset_q_empty", 80'(exp_q.size()), 80'(0));

        // Back-to-back words with the consumer always ready.
        out_tready = 1'b1;
        send_word(w_a, 1'b0);
        send_word(w_k, 1'b0);
        idle(4);

        // Backpressure: word held upper-half-first for five stalled cycles.
        out_tready = 1'b0;
        send_word(w_a, 1'b0);
        idle(5);
        out_tready = 1'b1;
        idle(3);

        // Sparse input: one word every fourth cycle, drains to empty in between.
        for (int k = 0; k < 3; k++) begin
            send_word(w_d, 1'b0);
            idle(3);
        end

        // Reset while the lower half is still pending.
        out_tready = 1'b1;
        send_word(w_a, 1'b0);
        idle(1);
        areset     = 1'b1;
        out_tready = 1'b0;
        idle(1);
        areset     = 1'b0;
        out_tready = 1'b1;
        idle(3);

        // tlast lands on the second beat only.
        send_word(w_a, 1'b1);
        idle(3);

        // Random input traffic and consumer backpressure.
        for (int i = 0; i < 50; i++) begin
            r          = {$urandom(), $urandom(), $urandom()};
            in_tdata   = r[2*W-1:0];
            in_tlast   = 1'($urandom_range(0, 1));
            in_tvalid  = 1'($urandom_range(0, 1));
            out_tready = 1'($urandom_range(0, 1));
            cycle(hs);
        end
        in_tvalid  = 1'b0;
        out_tready = 1'b1;
        budget     = 0;
        while (exp_q.size() != 0 && budget < 1000) begin
            cycle(hs);
            budget++;
        end
        chk("drain_q_empty", 80'(exp_q.size()), 80'(0));
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
